// File: rtl/status_reg_pkg.sv
// status_reg_pkg
//   Shared types for the execute-stage status register and the branch unit.
//   flags_t  : packed flag set, bit order {overflow, negative, carry, zero}
//   cond_e   : 4-bit condition code
//   eval_cond: evaluates a condition code against a flag set
package status_reg_pkg;

    typedef struct packed {
        logic overflow;
        logic negative;
        logic carry;
        logic zero;
    } flags_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    function automatic logic eval_cond(input flags_t f, input cond_e c);
        logic res;
        case (c)
            COND_EQ: res = f.zero;
            COND_NE: res = !f.zero;
            COND_CS: res = f.carry;
            COND_CC: res = !f.carry;
            COND_MI: res = f.negative;
            COND_PL: res = !f.negative;
            COND_VS: res = f.overflow;
            COND_VC: res = !f.overflow;
            COND_HI: res = f.carry & !f.zero;
            COND_LS: res = !f.carry | f.zero;
            COND_GE: res = (f.negative == f.overflow);
            COND_LT: res = (f.negative != f.overflow);
            COND_GT: res = !f.zero & (f.negative == f.overflow);
            COND_LE: res = f.zero | (f.negative != f.overflow);
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/status_reg_stack_if.sv
// status_reg_stack_if
//   Bundles the ALU-side control/data inputs and the status outputs of
//   status_reg_stack.
//   master: drives upd_en, upd_mask, D_*, push, pop, clr_err, cond
//   slave : drives flags, cond_true, count, full, empty, stack_err
interface status_reg_stack_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             upd_en;
    logic [3:0]       upd_mask;
    logic             D_zero;
    logic             D_carry;
    logic             D_negative;
    logic             D_overflow;
    logic             push;
    logic             pop;
    logic             clr_err;
    logic [3:0]       cond;
    logic [3:0]       flags;
    logic             cond_true;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             stack_err;

    modport master (
        output upd_en, upd_mask, D_zero, D_carry, D_negative, D_overflow,
               push, pop, clr_err, cond,
        input  flags, cond_true, count, full, empty, stack_err
    );

    modport slave (
        input  upd_en, upd_mask, D_zero, D_carry, D_negative, D_overflow,
               push, pop, clr_err, cond,
        output flags, cond_true, count, full, empty, stack_err
    );

endinterface

// File: rtl/flag_lifo.sv
// flag_lifo
//   DEPTH-entry LIFO of flag sets with push, pop and swap (push+pop).
//   clk, rst : clock, async active-high reset (clears occupancy only)
//   push/pop : requests; illegal ones (push when full, pop when empty)
//              are ignored here, the caller flags the error
//   din      : flag set to save
//   top      : entry at count-1 (meaningless when empty)
//   count    : occupancy; full/empty decoded from it
module flag_lifo
    import status_reg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  flags_t                       din,
    output flags_t                       top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    flags_t           mem [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;
    logic             do_push;
    logic             do_pop;
    logic             do_swap;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign wr_idx  = IDX_W'(cnt);
    assign top_idx = IDX_W'(cnt - CNT_W'(1));
    assign top     = mem[top_idx];
    assign count   = cnt;

    // push+pop on an empty stack degrades to a plain push
    assign do_push = push & ((!pop & !full) | (pop & empty));
    assign do_pop  = pop & !push & !empty;
    assign do_swap = push & pop & !empty;

    // Storage carries no reset: contents are unreachable once cnt is cleared
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end else if (do_swap) begin
            mem[top_idx] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (do_push) begin
            cnt <= cnt + CNT_W'(1);
        end else if (do_pop) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/status_reg_stack.sv
// status_reg_stack
//   Execute-stage flag register with masked ALU capture, a save/restore
//   LIFO for interrupt/call context, sticky stack error and condition
//   code evaluation.
//   clk, rst : clock, async active-high reset
//   bus      : status_reg_stack_if slave modport
//              (inputs upd_en, upd_mask, D_*, push, pop, clr_err, cond;
//               outputs flags, cond_true, count, full, empty, stack_err)
module status_reg_stack
    import status_reg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    status_reg_stack_if.slave    bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    flags_t           flags_q;
    flags_t           alu_d;
    flags_t           upd_val;
    flags_t           lifo_top;
    logic [CNT_W-1:0] lifo_count;
    logic             lifo_full;
    logic             lifo_empty;
    logic             restore;
    logic             err_set;
    logic             stack_err_q;

    flag_lifo #(
        .DEPTH(DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.push),
        .pop   (bus.pop),
        .din   (flags_q),
        .top   (lifo_top),
        .count (lifo_count),
        .full  (lifo_full),
        .empty (lifo_empty)
    );

    always_comb begin
        alu_d          = '0;
        alu_d.overflow = bus.D_overflow;
        alu_d.negative = bus.D_negative;
        alu_d.carry    = bus.D_carry;
        alu_d.zero     = bus.D_zero;
        upd_val        = flags_t'((flags_q & ~bus.upd_mask) | (alu_d & bus.upd_mask));
    end

    // Any legal pop (plain or swap) restores flags and overrides an ALU update
    assign restore = bus.pop & !lifo_empty;
    assign err_set = (bus.push & !bus.pop & lifo_full) | (bus.pop & lifo_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (restore) begin
            flags_q <= lifo_top;
        end else if (bus.upd_en) begin
            flags_q <= upd_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stack_err_q <= 1'b0;
        end else if (err_set) begin
            stack_err_q <= 1'b1;
        end else if (bus.clr_err) begin
            stack_err_q <= 1'b0;
        end
    end

    assign bus.flags     = flags_q;
    assign bus.cond_true = eval_cond(flags_q, cond_e'(bus.cond));
    assign bus.count     = lifo_count;
    assign bus.full      = lifo_full;
    assign bus.empty     = lifo_empty;
    assign bus.stack_err = stack_err_q;

endmodule

// File: tb/tb_status_reg_stack.sv
// tb_status_reg_stack
//   Randomized bench for status_reg_stack against a queue-based reference
//   model, preceded by directed scenarios with hand-computed expectations.
module tb_status_reg_stack;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    status_reg_stack_if #(.DEPTH(DEPTH)) bus ();

    status_reg_stack #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // reference model state
    logic [3:0] m_flags;
    logic [3:0] stk[$];
    logic       m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Condition codes come in true/inverted pairs: cond[3:1] picks the
    // predicate, cond[0] inverts it (AL/NV being "always" and its inverse).
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
        logic z, cy, n, v, base;
        z = f[0]; cy = f[1]; n = f[2]; v = f[3];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & !z;
            3'd5: base = (n == v);
            3'd6: base = !z & (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    // 32-bit ALU flags {V,N,C,Z}; subtract carry means "no borrow"
    function automatic logic [3:0] alu(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] bb, r;
        logic [32:0] s;
        bb = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + 33'(sub);
        r  = s[31:0];
        return {(a[31] == bb[31]) && (r[31] != a[31]), r[31], s[32], r == 32'd0};
    endfunction

    function automatic logic [3:0] masked(input logic [3:0] cur);
        logic [3:0] d;
        d = {bus.D_overflow, bus.D_negative, bus.D_carry, bus.D_zero};
        if (!bus.upd_en) return cur;
        return (cur & ~bus.upd_mask) | (d & bus.upd_mask);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_flags = 4'h0;
            stk.delete();
            m_err   = 1'b0;
        end else begin
            logic       e;
            logic [3:0] nf;
            e  = 1'b0;
            nf = masked(m_flags);
            if (bus.push && bus.pop) begin
                if (stk.size() > 0) begin
                    nf = stk[stk.size()-1];
                    stk[stk.size()-1] = m_flags;
                end else begin
                    e = 1'b1;
                    stk.push_back(m_flags);
                end
            end else if (bus.push) begin
                if (stk.size() == DEPTH) e = 1'b1;
                else stk.push_back(m_flags);
            end else if (bus.pop) begin
                if (stk.size() > 0) nf = stk.pop_back();
                else e = 1'b1;
            end
            m_flags = nf;
            if (e) m_err = 1'b1;
            else if (bus.clr_err) m_err = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("flags",     32'(bus.flags),     32'(m_flags));
            chk("count",     32'(bus.count),     32'(stk.size()));
            chk("full",      32'(bus.full),      32'(stk.size() == DEPTH));
            chk("empty",     32'(bus.empty),     32'(stk.size() == 0));
            chk("stack_err", 32'(bus.stack_err), 32'(m_err));
            chk("cond_true", 32'(bus.cond_true), 32'(ref_cond(m_flags, bus.cond)));
        end
    end

    task automatic set_in(input logic u, input logic [3:0] m, input logic [3:0] d,
                          input logic ps, input logic pp, input logic cl);
        bus.upd_en     = u;
        bus.upd_mask   = m;
        bus.D_overflow = d[3];
        bus.D_negative = d[2];
        bus.D_carry    = d[1];
        bus.D_zero     = d[0];
        bus.push       = ps;
        bus.pop        = pp;
        bus.clr_err    = cl;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_cond(input string nm, input logic [3:0] c, input logic exp);
        bus.cond = c;
        #1;
        chk(nm, 32'(bus.cond_true), 32'(exp));
    endtask

    initial begin
        logic [3:0] seq[4];
        logic [3:0] pops[4];
        seq  = '{4'h2, 4'h4, 4'h8, 4'h0};
        pops = '{4'h8, 4'h4, 4'h2, 4'h1};

        set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        bus.cond = 4'd14;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // reset asserted asynchronously in the middle of a push stream
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 4'hF, 4'($urandom), 1'b1, 1'b0, 1'b0);
            step();
        end
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_flags", 32'(bus.flags), 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_empty", 32'(bus.empty), 32'h1);
        chk("rst_err",   32'(bus.stack_err), 32'h0);
        chk_cond("rst_EQ", 4'd0, 1'b0);
        chk_cond("rst_PL", 4'd5, 1'b1);
        set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();

        // ALU ADD capture
        set_in(1'b1, 4'hF, alu(32'h8000_0000, 32'h8000_0010, 1'b0), 1'b0, 1'b0, 1'b0);
        step();
        chk("add_flags", 32'(bus.flags), 32'hA);
        chk_cond("add_VS", 4'd6, 1'b1);
        chk_cond("add_CS", 4'd2, 1'b1);
        chk_cond("add_LT", 4'd11, 1'b1);
        chk_cond("add_GE", 4'd10, 1'b0);

        // masked SUB capture: only Z taken
        set_in(1'b1, 4'b0001, alu(32'h0100_0000, 32'h0100_0000, 1'b1), 1'b0, 1'b0, 1'b0);
        step();
        chk("sub_flags", 32'(bus.flags), 32'hB);
        chk_cond("sub_GT", 4'd12, 1'b0);
        chk_cond("sub_LE", 4'd13, 1'b1);

        // fill, overflow, drain
        set_in(1'b1, 4'hF, 4'h1, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 4'hF, seq[i], 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("fill_full",  32'(bus.full), 32'h1);
        chk("fill_count", 32'(bus.count), 32'h4);
        set_in(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk("ovf_count", 32'(bus.count), 32'h4);
        chk("ovf_err",   32'(bus.stack_err), 32'h1);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
            step();
            chk("pop_order", 32'(bus.flags), 32'(pops[i]));
        end
        chk("drain_empty", 32'(bus.empty), 32'h1);

        // underflow with concurrent update, then clear
        set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        step();
        chk("clr1_err", 32'(bus.stack_err), 32'h0);
        set_in(1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0);
        step();
        chk("unf_err",   32'(bus.stack_err), 32'h1);
        chk("unf_flags", 32'(bus.flags), 32'h5);
        chk("unf_count", 32'(bus.count), 32'h0);
        set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        step();
        chk("clr2_err", 32'(bus.stack_err), 32'h0);

        // swap, then pop beating an update
        set_in(1'b1, 4'hF, 4'hC, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 4'hF, 4'h3, 1'b1, 1'b0, 1'b0);
        step();
        chk("pre_swap_flags", 32'(bus.flags), 32'h3);
        set_in(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
        step();
        chk("swap_flags", 32'(bus.flags), 32'hC);
        chk("swap_count", 32'(bus.count), 32'h1);
        set_in(1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
        step();
        chk("swap_pop_flags", 32'(bus.flags), 32'h3);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            set_in(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                   ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 35),
                   ($urandom_range(0, 99) < 10));
            bus.cond = 4'($urandom);
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
        end

        set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
